// File: rtl/modexp_sequencer.sv
// Left-to-right square-and-multiply sequencer computing x^e mod n by driving an
// external 2N-wide combinational ALU, one multiply or modulo operation per clock.
module modexp_sequencer #(
    parameter int N = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   e,
    input  logic [N-1:0]   n,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [N-1:0]   result,
    output logic [2*N-1:0] alu_a,
    output logic [2*N-1:0] alu_b,
    output logic [3:0]     alu_sel,
    input  logic [2*N-1:0] alu_out
);

    localparam int W  = 2 * N;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [3:0] OP_NONE = 4'b0000;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_MOD  = 4'b0100;

    typedef enum logic [2:0] {
        IDLE, REDUCE, SQ_MUL, SQ_MOD, MU_MUL, MU_MOD, FINISH
    } state_t;

    state_t        state, state_n;
    logic [N-1:0]  x_r, e_r, n_r, x_n, e_n, n_n;
    logic [N-1:0]  acc, acc_n, base, base_n;
    logic [W-1:0]  prod, prod_n;
    logic [IW-1:0] idx, idx_n;
    logic          busy_n, done_n, err_n;
    logic [N-1:0]  result_n;
    logic [W-1:0]  alu_a_n, alu_b_n;
    logic [3:0]    alu_sel_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            x_r     <= '0;
            e_r     <= '0;
            n_r     <= '0;
            acc     <= '0;
            base    <= '0;
            prod    <= '0;
            idx     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            result  <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= OP_NONE;
        end else begin
            state   <= state_n;
            x_r     <= x_n;
            e_r     <= e_n;
            n_r     <= n_n;
            acc     <= acc_n;
            base    <= base_n;
            prod    <= prod_n;
            idx     <= idx_n;
            busy    <= busy_n;
            done    <= done_n;
            err     <= err_n;
            result  <= result_n;
            alu_a   <= alu_a_n;
            alu_b   <= alu_b_n;
            alu_sel <= alu_sel_n;
        end
    end

    always_comb begin
        state_n  = state;
        x_n      = x_r;
        e_n      = e_r;
        n_n      = n_r;
        acc_n    = acc;
        base_n   = base;
        prod_n   = prod;
        idx_n    = idx;
        err_n    = err;
        result_n = result;

        case (state)
            IDLE: begin
                if (start) begin
                    x_n      = x;
                    e_n      = e;
                    n_n      = n;
                    acc_n    = N'(1);
                    base_n   = '0;
                    prod_n   = '0;
                    idx_n    = IW'(N - 1);
                    result_n = '0;
                    err_n    = (n == '0);
                    state_n  = (n == '0) ? FINISH : REDUCE;
                end
            end
            REDUCE: begin
                base_n  = alu_out[N-1:0];
                state_n = SQ_MUL;
            end
            SQ_MUL: begin
                prod_n  = alu_out;
                state_n = SQ_MOD;
            end
            SQ_MOD: begin
                acc_n = alu_out[N-1:0];
                if (e_r[idx]) begin
                    state_n = MU_MUL;
                end else if (idx == '0) begin
                    state_n = FINISH;
                end else begin
                    idx_n   = idx - 1'b1;
                    state_n = SQ_MUL;
                end
            end
            MU_MUL: begin
                prod_n  = alu_out;
                state_n = MU_MOD;
            end
            MU_MOD: begin
                acc_n = alu_out[N-1:0];
                if (idx == '0) begin
                    state_n = FINISH;
                end else begin
                    idx_n   = idx - 1'b1;
                    state_n = SQ_MUL;
                end
            end
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Outputs are decoded from the next state so they are registered and stable for the whole op cycle.
        busy_n    = (state_n != IDLE);
        done_n    = (state_n == FINISH);
        alu_a_n   = '0;
        alu_b_n   = '0;
        alu_sel_n = OP_NONE;
        if (state_n == FINISH && state != FINISH) begin
            result_n = err_n ? '0 : acc_n;
        end

        case (state_n)
            REDUCE: begin
                alu_a_n   = W'(x_n);
                alu_b_n   = W'(n_n);
                alu_sel_n = OP_MOD;
            end
            SQ_MUL: begin
                alu_a_n   = W'(acc_n);
                alu_b_n   = W'(acc_n);
                alu_sel_n = OP_MUL;
            end
            SQ_MOD, MU_MOD: begin
                alu_a_n   = prod_n;
                alu_b_n   = W'(n_n);
                alu_sel_n = OP_MOD;
            end
            MU_MUL: begin
                alu_a_n   = W'(acc_n);
                alu_b_n   = W'(base_n);
                alu_sel_n = OP_MUL;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_modexp_sequencer.sv
// Directed and randomized checks of modexp_sequencer against a behavioural ALU
// and an independent repeated-multiplication reference.
module tb_modexp_sequencer;

    localparam int N = 6;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [N-1:0]   x = '0, e = '0, n = '0;
    logic           busy, done, err;
    logic [N-1:0]   result;
    logic [2*N-1:0] alu_a, alu_b, alu_out;
    logic [3:0]     alu_sel;

    int errors = 0;
    int checks = 0;

    modexp_sequencer #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .x(x), .e(e), .n(n),
        .busy(busy), .done(done), .err(err), .result(result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_out = '0;
        if (alu_sel == 4'b0010)
            alu_out = alu_a * alu_b;
        else if (alu_sel == 4'b0100 && alu_b != '0)
            alu_out = alu_a % alu_b;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_modexp(input int xv, input int ev, input int nv);
        int r;
        if (nv == 0) return 0;
        r = 1 % nv;
        for (int k = 0; k < ev; k++) r = (r * xv) % nv;
        return r;
    endfunction

    task automatic run(input string tag, input logic [N-1:0] xv, input logic [N-1:0] ev,
                       input logic [N-1:0] nv, input int exp_res, input int exp_lat,
                       input int exp_err, input bit glitch);
        int cyc;
        int sel_bad = 0;
        int busy_bad = 0;
        logic [3:0] exp_sel[$];
        if (nv != 0) begin
            exp_sel.push_back(4'b0100);
            for (int k = N - 1; k >= 0; k--) begin
                exp_sel.push_back(4'b0010);
                exp_sel.push_back(4'b0100);
                if (ev[k]) begin
                    exp_sel.push_back(4'b0010);
                    exp_sel.push_back(4'b0100);
                end
            end
        end
        @(negedge clk);
        x = xv; e = ev; n = nv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (cyc <= 200) begin
            if (glitch && cyc >= 3 && cyc <= 10) begin
                start = 1'b1; x = xv + 6'd7; e = ev ^ 6'h2a; n = 6'd11;
            end else begin
                start = 1'b0;
            end
            if (!busy) busy_bad++;
            if (done) break;
            if (cyc - 1 < exp_sel.size()) begin
                if (alu_sel != exp_sel[cyc-1]) sel_bad++;
            end else begin
                sel_bad++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check({tag, "_latency"}, done ? cyc : -1, exp_lat);
        check({tag, "_result"}, int'(result), exp_res);
        check({tag, "_err"}, int'(err), exp_err);
        check({tag, "_finish_sel"}, int'(alu_sel), 0);
        check({tag, "_sel_seq_bad"}, sel_bad, 0);
        check({tag, "_busy_low"}, busy_bad, 0);
        @(posedge clk); #1;
        check({tag, "_idle_busy"}, int'(busy), 0);
        check({tag, "_idle_done"}, int'(done), 0);
    endtask

    initial begin
        int cyc;
        int xr, er, nr;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_result", int'(result), 0);
        check("rst_sel", int'(alu_sel), 0);
        check("rst_alu_a", int'(alu_a), 0);

        run("t1", 6'd5, 6'd3, 6'd13, 8, 18, 0, 1'b0);
        run("t2", 6'd45, 6'd5, 6'd7, 5, 18, 0, 1'b0);
        run("t3", 6'd60, 6'd0, 6'd7, 1, 14, 0, 1'b0);
        run("t4", 6'd9, 6'd63, 6'd1, 0, 26, 0, 1'b0);
        run("nzero", 6'd37, 6'd20, 6'd0, 0, 1, 1, 1'b0);
        run("glitch", 6'd5, 6'd3, 6'd13, 8, 18, 0, 1'b1);

        // reset in cycle 6 of a run
        @(negedge clk);
        x = 6'd45; e = 6'd5; n = 6'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_err", int'(err), 0);
        check("mid_rst_result", int'(result), 0);
        check("mid_rst_alu_a", int'(alu_a), 0);
        check("mid_rst_alu_b", int'(alu_b), 0);
        check("mid_rst_sel", int'(alu_sel), 0);
        @(posedge clk); #1;
        check("mid_rst_no_done", int'(done), 0);
        run("after_rst", 6'd5, 6'd3, 6'd13, 8, 18, 0, 1'b0);

        // start held through FINISH: ignored there, accepted in the following IDLE cycle
        @(negedge clk);
        x = 6'd45; e = 6'd5; n = 6'd7; start = 1'b1;
        @(posedge clk); #1;
        cyc = 1;
        while (!done && cyc <= 200) begin @(posedge clk); #1; cyc++; end
        check("hold_latency", done ? cyc : -1, 18);
        @(posedge clk); #1;
        check("hold_idle_busy", int'(busy), 0);
        @(posedge clk); #1;
        start = 1'b0;
        check("hold_reaccept_busy", int'(busy), 1);
        check("hold_reaccept_sel", int'(alu_sel), 4);
        cyc = 1;
        while (!done && cyc <= 200) begin @(posedge clk); #1; cyc++; end
        check("hold_second_latency", done ? cyc : -1, 18);
        check("hold_second_result", int'(result), 5);
        @(posedge clk); #1;

        for (int t = 0; t < 12; t++) begin
            xr = $urandom_range(0, 63);
            er = $urandom_range(0, 63);
            nr = $urandom_range(2, 63);
            run($sformatf("rnd%0d", t), N'(xr), N'(er), N'(nr), ref_modexp(xr, er, nr),
                2 * N + 2 * $countones(N'(er)) + 2, 0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
